// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external 2-stage registered adder among N_REQ requesters.
// Optional per-requester issue counters are built when ADDER_SCHED_STATS_EN is defined.
module adder_rr_sched #(
    parameter int N_REQ      = 4,
    parameter int ADD_LAT    = 2,
    parameter int RESP_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [8:0]           add_sum,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [8:0]           resp_sum,
    output logic [ID_W-1:0]      resp_id,
`ifdef ADDER_SCHED_STATS_EN
    output logic [16*N_REQ-1:0]  grant_cnt,
    input  logic                 stats_clr,
`endif
    output logic                 busy
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr_q;
    logic [7:0]       add_a_q;
    logic [7:0]       add_b_q;
    logic [ADD_LAT:0] pipe_vld_q;
    logic [ID_W-1:0]  pipe_id_q [ADD_LAT+1];
    logic [CNT_W-1:0] credit_q;
    logic [CNT_W-1:0] credit_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [8:0]       mem_sum_q [RESP_DEPTH];
    logic [ID_W-1:0]  mem_id_q  [RESP_DEPTH];

    logic             found_s;
    logic [ID_W-1:0]  winner_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;

    // Search for the first valid requester after the pointer, wrapping around.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!found_s && req_valid[(int'(rr_ptr_q) + off) % N_REQ]) begin
                found_s  = 1'b1;
                winner_s = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
            end else begin
                found_s  = found_s;
            end
        end
    end

    assign issue_s = found_s && (credit_q != '0) && !rst;
    assign push_s  = pipe_vld_q[ADD_LAT];
    assign pop_s   = resp_valid && resp_ready;

    // One-hot grant, gated by available credit.
    always_comb begin
        req_ready = '0;
        if (issue_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Credit and FIFO occupancy next-state; a simultaneous +1/-1 cancels out.
    always_comb begin
        credit_d = credit_q - CNT_W'(issue_s) + CNT_W'(pop_s);
        cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Arbitration pointer, adder operands, tag pipe and response FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= ID_W'(N_REQ - 1);
            add_a_q    <= 8'h00;
            add_b_q    <= 8'h00;
            pipe_vld_q <= '0;
            credit_q   <= CNT_W'(RESP_DEPTH);
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int s = 0; s <= ADD_LAT; s++) begin
                pipe_id_q[s] <= '0;
            end
            for (int e = 0; e < RESP_DEPTH; e++) begin
                mem_sum_q[e] <= 9'h000;
                mem_id_q[e]  <= '0;
            end
        end else begin
            if (issue_s) begin
                rr_ptr_q <= winner_s;
                add_a_q  <= req_a[8*winner_s +: 8];
                add_b_q  <= req_b[8*winner_s +: 8];
            end
            pipe_vld_q   <= {pipe_vld_q[ADD_LAT-1:0], issue_s};
            pipe_id_q[0] <= winner_s;
            for (int s = 1; s <= ADD_LAT; s++) begin
                pipe_id_q[s] <= pipe_id_q[s-1];
            end
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            if (push_s) begin
                mem_sum_q[wr_ptr_q] <= add_sum;
                mem_id_q[wr_ptr_q]  <= pipe_id_q[ADD_LAT];
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign resp_valid = (cnt_q != '0);
    assign resp_sum   = mem_sum_q[rd_ptr_q];
    assign resp_id    = mem_id_q[rd_ptr_q];
    assign busy       = (|pipe_vld_q) || (cnt_q != '0);

`ifdef ADDER_SCHED_STATS_EN
    logic [15:0] gcnt_q [N_REQ];

    // Saturating per-requester issue counters; clear has priority over increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst || stats_clr) begin
                gcnt_q[i] <= 16'h0000;
            end else if (issue_s && (winner_s == ID_W'(i)) && (gcnt_q[i] != 16'hFFFF)) begin
                gcnt_q[i] <= gcnt_q[i] + 16'h0001;
            end else begin
                gcnt_q[i] <= gcnt_q[i];
            end
        end
    end

    // Pack counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[16*i +: 16] = gcnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Scoreboard bench for adder_rr_sched with a behavioural 2-stage registered adder.
module tb_adder_rr_sched;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [8*N-1:0]      req_a;
    logic [8*N-1:0]      req_b;
    logic [N-1:0]        req_ready;
    logic [7:0]          add_a;
    logic [7:0]          add_b;
    logic [8:0]          add_sum;
    logic                resp_valid;
    logic                resp_ready;
    logic [8:0]          resp_sum;
    logic [ID_W-1:0]     resp_id;
    logic                busy;
`ifdef ADDER_SCHED_STATS_EN
    logic [16*N-1:0]     grant_cnt;
    logic                stats_clr;
`endif

    logic [7:0]          adr_a_q;
    logic [7:0]          adr_b_q;
    logic [8:0]          adr_sum_q;

    logic [ID_W+8:0]     sb_q[$];
    int                  grant_q[$];
    int                  n_checks = 0;
    int                  n_fail   = 0;
    int                  n_pop    = 0;
    logic [8:0]          last_sum;

    adder_rr_sched #(.N_REQ(N), .ADD_LAT(2), .RESP_DEPTH(4), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
`ifdef ADDER_SCHED_STATS_EN
        .grant_cnt  (grant_cnt),
        .stats_clr  (stats_clr),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // External adder: operand registers then sum register, no reset.
    always @(posedge clk) begin
        adr_a_q   <= add_a;
        adr_b_q   <= add_b;
        adr_sum_q <= {1'b0, adr_a_q} + {1'b0, adr_b_q};
    end
    assign add_sum = adr_sum_q;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: record issues into the scoreboard, compare every popped response.
    always @(negedge clk) begin
        logic [ID_W+8:0] e;
        if (rst) begin
            sb_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    sb_q.push_back({ID_W'(i), {1'b0, req_a[8*i +: 8]} + {1'b0, req_b[8*i +: 8]}});
                    grant_q.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("resp_sum", 32'(resp_sum), 32'(e[8:0]));
                    check_val("resp_id", 32'(resp_id), 32'(e[ID_W+8:9]));
                end
                last_sum = resp_sum;
                n_pop++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        check_val("idle_reached", 32'(ok), 32'd1);
        tick();
    endtask

    initial begin
        int lat;
        int base;
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        logic [8:0] hold_sum;
        logic [ID_W-1:0] hold_id;

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
`ifdef ADDER_SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        tick();
        tick();
        @(negedge clk);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_sum", 32'(resp_sum), 32'd0);
        check_val("rst_resp_id", 32'(resp_id), 32'd0);
        check_val("rst_add_a", 32'(add_a), 32'd0);
        check_val("rst_add_b", 32'(add_b), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single op with latency measurement.
        req_valid = 4'b0001;
        req_a[7:0] = 8'h12;
        req_b[7:0] = 8'h34;
        @(negedge clk);
        check_val("single_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        check_val("single_latency", 32'(lat), 32'd4);
        check_val("single_sum", 32'(resp_sum), 32'h046);
        wait_idle();

        // Carry out into bit 8.
        req_valid = 4'b0100;
        req_a[23:16] = 8'hFF;
        req_b[23:16] = 8'hFF;
        @(negedge clk);
        check_val("carry_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        wait_idle();
        check_val("carry_sum", 32'(last_sum), 32'h1FE);

        // Round-robin from a fresh pointer.
        do_reset();
        grant_q.delete();
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = 8'($urandom_range(0, 255));
            req_b[8*i +: 8] = 8'($urandom_range(0, 255));
        end
        req_valid = 4'hF;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (grant_q.size() >= 6) break;
            tick();
        end
        tick();
        req_valid = '0;
        check_val("rr_count", 32'(grant_q.size() >= 6), 32'd1);
        for (int j = 0; j < 6; j++) begin
            if (j < grant_q.size()) check_val("rr_order", 32'(grant_q[j]), 32'(exp_order[j]));
        end
        wait_idle();

        // Backpressure: credit limits issues to FIFO depth.
        grant_q.delete();
        resp_ready = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < 12; c++) tick();
        @(negedge clk);
        check_val("bp_issues", 32'(grant_q.size()), 32'd4);
        check_val("bp_blocked", 32'(req_ready), 32'd0);
        check_val("bp_valid", 32'(resp_valid), 32'd1);
        hold_sum = resp_sum;
        hold_id = resp_id;
        tick();
        tick();
        tick();
        @(negedge clk);
        check_val("bp_stable_sum", 32'(resp_sum), 32'(hold_sum));
        check_val("bp_stable_id", 32'(resp_id), 32'(hold_id));
        base = n_pop;
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        @(negedge clk);
        check_val("bp_one_more", 32'(grant_q.size()), 32'd5);
        tick();
        req_valid = '0;
        resp_ready = 1'b1;
        wait_idle();
        check_val("bp_pops", 32'(n_pop - base), 32'd5);

        // Reset while two ops are in flight.
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_valid", 32'(resp_valid), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            check_val("mid_rst_stale", 32'(resp_valid), 32'd0);
        end
        tick();

`ifdef ADDER_SCHED_STATS_EN
        // Saturating counters and clear.
        do_reset();
        grant_q.delete();
        req_valid = 4'b0010;
        for (int c = 0; c < 95000; c++) begin
            tick();
            if (grant_q.size() >= 70000) break;
        end
        req_valid = '0;
        wait_idle();
        check_val("stats_cnt1", 32'(grant_cnt[31:16]), 32'hFFFF);
        check_val("stats_cnt0", 32'(grant_cnt[15:0]), 32'h0);
        check_val("stats_cnt23", 32'(grant_cnt[63:32]), 32'h0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        @(negedge clk);
        check_val("stats_clr_lo", grant_cnt[31:0], 32'h0);
        check_val("stats_clr_hi", grant_cnt[63:32], 32'h0);
        tick();
`endif

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
